led_pattern_engine: RTL and testbench

LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

---
 rtl/led_pattern_pkg.sv | 32 +++
 rtl/led_pattern_engine_debounce.sv | 56 +++++
 rtl/led_pattern_engine.sv | 179 +++++++++++++++++
 tb/tb_led_pattern_engine.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - mode encodings and shared constants for led_pattern_engine
// LED_PATTERN_BREATHE_EN selects whether mode 3 (BREATHE) exists in the mode ring.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int SPEED_MAX = 4;
  localparam int SPEED_RST = 2;
  localparam int SPEED_W   = 3;
  localparam int PWM_W     = 8;
  localparam int DUTY_STEP = 16;
  localparam int DUTY_TOP  = (1 << PWM_W) - DUTY_STEP;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_BLINK: return MODE_CHASE;
      MODE_CHASE: return MODE_COUNT;
`ifdef LED_PATTERN_BREATHE_EN
      MODE_COUNT: return MODE_BREATHE;
`else
      MODE_COUNT: return MODE_BLINK;
`endif
      default:    return MODE_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_engine_debounce.sv
// rtl/led_pattern_engine_debounce.sv - button synchroniser, debouncer and press pulse
// A press is only reported once the button has been seen stably released since reset.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             cand;
  logic             level;
  logic             armed;
  logic [CNT_W-1:0] run;
  logic             settle;

  // run counts consecutive identical synchronised samples; settle fires on the Nth one
  assign settle = (sync2 == cand) && (run == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cand  <= 1'b0;
      run   <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      cand  <= sync2;
      press <= 1'b0;
      if (sync2 != cand) begin
        run <= CNT_W'(1);
      end else if (run != CNT_FULL) begin
        run <= run + CNT_W'(1);
      end
      if (settle) begin
        level <= sync2;
        if (!sync2) begin
          armed <= 1'b1;
        end
        press <= sync2 && !level && armed;
      end
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - button-driven LED pattern generator (BLINK/CHASE/COUNT/BREATHE)
// BREATHE mode and its PWM logic exist only when LED_PATTERN_BREATHE_EN is defined.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int N_LED           = 5,
  parameter int BASE_DIV        = 750000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BTN1,
  input  logic             BTN2,
  input  logic             BTN3,
  output logic [N_LED-1:0] LED,
  output logic [1:0]       MODE,
  output logic             TICK
);

  localparam int DIV_W = $clog2(BASE_DIV * (1 << SPEED_MAX) + 1);

  logic press_mode;
  logic press_slow;
  logic press_fast;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk(CLK), .rst_n(RST_N), .btn(BTN1), .press(press_mode)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn2 (
    .clk(CLK), .rst_n(RST_N), .btn(BTN2), .press(press_slow)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn3 (
    .clk(CLK), .rst_n(RST_N), .btn(BTN3), .press(press_fast)
  );

  // BTN1 always wins; BTN2 and BTN3 together cancel each other out
  logic act_mode;
  logic act_slow;
  logic act_fast;

  assign act_mode = press_mode;
  assign act_slow = press_slow && !press_mode && !press_fast;
  assign act_fast = press_fast && !press_mode && !press_slow;

  mode_e              mode_q;
  mode_e              mode_d;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] speed_d;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   period_m1;
  logic               restart;
  logic               tick;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q  <= MODE_BLINK;
      speed_q <= SPEED_W'(SPEED_RST);
    end else begin
      mode_q  <= mode_d;
      speed_q <= speed_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    if (act_mode) begin
      mode_d = next_mode(mode_q);
    end else if (act_slow && (speed_q != SPEED_W'(SPEED_MAX))) begin
      speed_d = speed_q + SPEED_W'(1);
    end else if (act_fast && (speed_q != '0)) begin
      speed_d = speed_q - SPEED_W'(1);
    end
  end

  // a saturated speed press is not a change and leaves the divider running
  assign restart   = (mode_d != mode_q) || (speed_d != speed_q);
  assign period_m1 = (DIV_W'(BASE_DIV) << speed_q) - DIV_W'(1);
  assign tick      = (div_q == period_m1) && !restart;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
    end else if (restart || (div_q == period_m1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign TICK = tick;
  assign MODE = mode_q;

  logic [N_LED-1:0] breathe_led;

`ifdef LED_PATTERN_BREATHE_EN
  logic [PWM_W-1:0] pwm;
  logic [PWM_W-1:0] duty;
  logic             ramp_up;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm     <= '0;
      duty    <= '0;
      ramp_up <= 1'b1;
    end else begin
      pwm <= pwm + PWM_W'(1);
      if (act_mode) begin
        duty    <= '0;
        ramp_up <= 1'b1;
      end else if (tick && (mode_q == MODE_BREATHE)) begin
        if (ramp_up) begin
          if (duty == PWM_W'(DUTY_TOP)) begin
            duty    <= duty - PWM_W'(DUTY_STEP);
            ramp_up <= 1'b0;
          end else begin
            duty <= duty + PWM_W'(DUTY_STEP);
          end
        end else begin
          if (duty == '0) begin
            duty    <= PWM_W'(DUTY_STEP);
            ramp_up <= 1'b1;
          end else begin
            duty <= duty - PWM_W'(DUTY_STEP);
          end
        end
      end
    end
  end

  assign breathe_led = {N_LED{pwm < duty}};
`else
  assign breathe_led = '0;
`endif

  logic chase_up;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED      <= '0;
      chase_up <= 1'b1;
    end else if (act_mode) begin
      chase_up <= 1'b1;
      LED      <= (mode_d == MODE_CHASE) ? N_LED'(1) : '0;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (tick) LED <= ~LED;
        end
        MODE_CHASE: begin
          if (tick) begin
            if (chase_up) begin
              if (LED[N_LED-1]) begin
                LED      <= LED >> 1;
                chase_up <= 1'b0;
              end else begin
                LED <= LED << 1;
              end
            end else begin
              if (LED[0]) begin
                LED      <= LED << 1;
                chase_up <= 1'b1;
              end else begin
                LED <= LED >> 1;
              end
            end
          end
        end
        MODE_COUNT: begin
          if (tick) LED <= LED + N_LED'(1);
        end
        default: begin
          LED <= breathe_led;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed self-checking bench for led_pattern_engine
// Mode-3 checks are compiled in only with LED_PATTERN_BREATHE_EN.
module tb_led_pattern_engine;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BTN1;
  logic       BTN2;
  logic       BTN3;
  logic [4:0] LED;
  logic [1:0] MODE;
  logic       TICK;

  int total = 0;
  int bad   = 0;
  int n;

`ifdef LED_PATTERN_BREATHE_EN
  localparam int M_AFTER_COUNT  = 3;
  localparam int M_AFTER_GLITCH = 0;
`else
  localparam int M_AFTER_COUNT  = 0;
  localparam int M_AFTER_GLITCH = 1;
`endif

  led_pattern_engine #(
    .N_LED(5), .BASE_DIV(4), .DEBOUNCE_CYCLES(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN1(BTN1), .BTN2(BTN2), .BTN3(BTN3),
    .LED(LED), .MODE(MODE), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while ((TICK !== 1'b1) && (cyc < 300));
    chk("tick_seen", 32'(TICK), 32'd1);
  endtask

  task automatic press(input logic [2:0] b);
    {BTN3, BTN2, BTN1} = b;
    repeat (6) @(negedge CLK);
    {BTN3, BTN2, BTN1} = 3'b000;
    repeat (6) @(negedge CLK);
  endtask

  task automatic hold_btn1(input logic v, input int cyc);
    BTN1 = v;
    repeat (cyc) @(negedge CLK);
  endtask

  logic [4:0] chase_exp [9];

  initial begin
    chase_exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                  5'b00100, 5'b00010, 5'b00001, 5'b00010};
    RST_N = 1'b0;
    {BTN3, BTN2, BTN1} = 3'b000;
    repeat (3) @(negedge CLK);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_mode", 32'(MODE), 32'd0);
    chk("rst_tick", 32'(TICK), 32'd0);

    // blink at speed 2: period 16, LED shown before each tick's update
    RST_N = 1'b1;
    wait_tick(n); chk("first_tick", n, 15); chk("blink_led0", 32'(LED), 32'd0);
    wait_tick(n); chk("period_16a", n, 16); chk("blink_led1", 32'(LED), 32'h1f);
    wait_tick(n); chk("period_16b", n, 16); chk("blink_led2", 32'(LED), 32'd0);

    // press latency: pulse after 5 cycles, visible on MODE the edge after
    BTN1 = 1'b1;
    repeat (5) @(negedge CLK);
    chk("lat_mode_before", 32'(MODE), 32'd0);
    @(negedge CLK);
    chk("lat_mode_after", 32'(MODE), 32'd1);
    chk("chase_init", 32'(LED), 32'd1);
    BTN1 = 1'b0;
    repeat (6) @(negedge CLK);
    for (int k = 0; k < 9; k++) begin
      wait_tick(n);
      @(negedge CLK);
      chk($sformatf("chase_%0d", k), 32'(LED), 32'(chase_exp[k]));
    end

    press(3'b001);
    chk("count_mode", 32'(MODE), 32'd2);
    chk("count_init", 32'(LED), 32'd0);
    for (int k = 1; k <= 33; k++) begin
      wait_tick(n);
      @(negedge CLK);
      chk($sformatf("count_%0d", k), 32'(LED), 32'(k % 32));
    end

    for (int k = 0; k < 5; k++) press(3'b010);
    wait_tick(n); wait_tick(n);
    chk("period_sat64", n, 64);
    press(3'b110);
    wait_tick(n); wait_tick(n);
    chk("period_b2b3", n, 64);
    chk("mode_b2b3", 32'(MODE), 32'd2);
    press(3'b101);
    chk("mode_b1b3", 32'(MODE), 32'(M_AFTER_COUNT));
    wait_tick(n); wait_tick(n);
    chk("period_b1b3", n, 64);
    press(3'b100);
    wait_tick(n); wait_tick(n);
    chk("period_fast32", n, 32);

    // 2-cycle bounces must be rejected; a 5-cycle level gives one press
    hold_btn1(1'b1, 2); hold_btn1(1'b0, 2); hold_btn1(1'b1, 2); hold_btn1(1'b0, 10);
    chk("glitch_none", 32'(MODE), 32'(M_AFTER_COUNT));
    hold_btn1(1'b1, 5); hold_btn1(1'b0, 12);
    chk("glitch_one", 32'(MODE), 32'(M_AFTER_GLITCH));
`ifdef LED_PATTERN_BREATHE_EN
    press(3'b001);
`endif
    chk("pre_rst_chase", 32'(MODE), 32'd1);

    wait_tick(n);
    BTN1 = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_led", 32'(LED), 32'd0);
    chk("async_rst_mode", 32'(MODE), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("held_no_press", 32'(MODE), 32'd0);
    BTN1 = 1'b0;
    repeat (8) @(negedge CLK);
    chk("released_no_press", 32'(MODE), 32'd0);
    press(3'b001);
    chk("repress_mode", 32'(MODE), 32'd1);
    chk("repress_led", 32'(LED), 32'd1);

`ifdef LED_PATTERN_BREATHE_EN
    press(3'b001);
    press(3'b001);
    chk("breathe_mode", 32'(MODE), 32'd3);
    for (int k = 1; k <= 30; k++) begin
      wait_tick(n);
      @(negedge CLK);
      if (k == 15) chk("duty_top", 32'(dut.duty), 32'd240);
      if (k == 30) chk("duty_bottom", 32'(dut.duty), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
